hr_4t16_demux_top: RTL and testbench

Receive-side counterpart of the half-rate 16:4 transmit mux. Takes four serial lanes, one bit per lane per clk_hr cycle, and reassembles 16-bit words every 4 cycles. A bit-slip word aligner locks the word boundary onto a training word. The recovered words and a word-valid strobe feed the PRBS checker and downstream logic in the clk_hr domain.

---
 rtl/hr_4t16_demux_top.sv | 154 +++++++++++++++
 tb/tb_hr_4t16_demux_top.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hr_4t16_demux_top.sv
// Half-rate 4:16 receive demux with bit-slip word aligner.
// Optional training-word error counter enabled by defining HR_4T16_DEMUX_ERRCNT_EN.
module hr_4t16_demux_top #(
   parameter logic [15:0] SYNC_WORD = 16'h1E2D,
   parameter int          LOCK_CNT  = 4,
   parameter int          MAX_SLIPS = 8
) (
   input  logic        clk_hr,
   input  logic        rst_n,
   input  logic [3:0]  din,
   input  logic        train,
   input  logic        slip_ext,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        locked,
   output logic        align_fail,
   output logic [7:0]  err_cnt
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
   localparam logic [3:0] SLIP_N = 4'(MAX_SLIPS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SEARCH, ST_CHECK, ST_DISCARD, ST_LOCKED, ST_FAIL
   } state_t;

   state_t state, state_nx;

   // The oldest bit of each lane's shift register is never part of a word, so only three are stored.
   logic [3:0][2:0] sr;
   logic [1:0]      ph;
   logic            slip_int, slip, capture, is_sync, train_q, train_rise;
   logic [15:0]     cap_word;
   logic [3:0]      match_cnt, match_nx, slip_cnt, slip_cnt_nx;
   logic            slip_req;

   always_comb begin
      cap_word = '0;
      for (int k = 0; k < 4; k++) begin
         cap_word[4*k +: 4] = {din[k], sr[k]};
      end
   end

   assign slip       = slip_ext | slip_int;
   assign capture    = (ph == 2'd3) && !slip;
   assign is_sync    = (cap_word == SYNC_WORD);
   assign train_rise = train & ~train_q;

   always_ff @(posedge clk_hr) begin
      if (!rst_n) begin
         sr       <= '0;
         ph       <= 2'd0;
         dout     <= 16'h0000;
         dout_vld <= 1'b0;
         train_q  <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            sr[k] <= {din[k], sr[k][2:1]};
         end
         if (!slip) begin
            ph <= ph + 2'd1;
         end
         dout_vld <= capture;
         if (capture) begin
            dout <= cap_word;
         end
         train_q <= train;
      end
   end

   // Aligner state register, together with its counters and the slip request pulse.
   always_ff @(posedge clk_hr) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         match_cnt <= 4'd0;
         slip_cnt  <= 4'd0;
         slip_int  <= 1'b0;
      end else begin
         state     <= state_nx;
         match_cnt <= match_nx;
         slip_cnt  <= slip_cnt_nx;
         slip_int  <= slip_req;
      end
   end

   always_comb begin
      state_nx    = state;
      match_nx    = match_cnt;
      slip_cnt_nx = slip_cnt;
      slip_req    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (train) begin
               state_nx    = ST_SEARCH;
               slip_cnt_nx = 4'd0;
            end
         end
         ST_SEARCH, ST_CHECK, ST_DISCARD: begin
            if (!train) begin
               state_nx = ST_IDLE;
            end else if (capture) begin
               if (state == ST_DISCARD) begin
                  state_nx = ST_SEARCH;
               end else if (is_sync) begin
                  match_nx = (state == ST_SEARCH) ? 4'd1 : match_cnt + 4'd1;
                  state_nx = (match_nx == LOCK_N) ? ST_LOCKED : ST_CHECK;
               end else if (slip_cnt == SLIP_N) begin
                  state_nx = ST_FAIL;
               end else begin
                  slip_req    = 1'b1;
                  slip_cnt_nx = slip_cnt + 4'd1;
                  state_nx    = ST_DISCARD;
               end
            end
         end
         ST_LOCKED: begin
            if (train_rise) begin
               state_nx    = ST_SEARCH;
               slip_cnt_nx = 4'd0;
            end
         end
         ST_FAIL: begin
            if (!train) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      locked     = (state == ST_LOCKED);
      align_fail = (state == ST_FAIL);
   end

`ifdef HR_4T16_DEMUX_ERRCNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk_hr) begin
      if (!rst_n) begin
         err_q <= 8'h00;
      end else if (state_nx == ST_SEARCH && state != ST_SEARCH) begin
         err_q <= 8'h00;
      end else if (state == ST_LOCKED && train && capture && !is_sync && err_q != 8'hFF) begin
         err_q <= err_q + 8'h01;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_hr_4t16_demux_top.sv
// Bench for hr_4t16_demux_top: bit-queue word model plus aligner model, checked every cycle,
// with directed scenarios pinned by hand-computed literals.
module tb_hr_4t16_demux_top;

   localparam logic [15:0] SYNC      = 16'h1E2D;
   localparam int          LOCK_CNT  = 4;
   localparam int          MAX_SLIPS = 8;

   localparam int M_IDLE = 0, M_SEARCH = 1, M_CHECK = 2, M_DISCARD = 3, M_LOCKED = 4, M_FAIL = 5;

   logic        clk_hr = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  din = 4'h0;
   logic        train = 1'b0;
   logic        slip_ext = 1'b0;
   logic [15:0] dout;
   logic        dout_vld, locked, align_fail;
   logic [7:0]  err_cnt;

   hr_4t16_demux_top #(.SYNC_WORD(SYNC), .LOCK_CNT(LOCK_CNT), .MAX_SLIPS(MAX_SLIPS)) dut (
      .clk_hr    (clk_hr),
      .rst_n     (rst_n),
      .din       (din),
      .train     (train),
      .slip_ext  (slip_ext),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .locked    (locked),
      .align_fail(align_fail),
      .err_cnt   (err_cnt)
   );

   always #5 clk_hr = ~clk_hr;

   int checks = 0;
   int failures = 0;
   int gpos = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: every edge appends one 4-lane column; a slip drops the oldest pending column,
   // otherwise four pending columns form a word.
   logic [3:0]  mq[$];
   logic [15:0] m_dout, m_w;
   logic        m_vld, m_locked, m_fail, m_cap, m_slp, m_rise, m_pend, m_prev_train, m_init;
   logic [3:0]  m_col;
   logic [7:0]  m_err;
   int          m_mode, m_old, m_matches, m_slips;

   initial begin
      m_init = 1'b0;
      m_pend = 1'b0;
      m_mode = M_IDLE;
   end

   always @(posedge clk_hr) begin
      if (!rst_n) begin
         mq.delete();
         m_dout = 16'h0000; m_vld = 1'b0; m_err = 8'h00;
         m_pend = 1'b0; m_prev_train = 1'b0;
         m_mode = M_IDLE; m_matches = 0; m_slips = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         m_slp  = slip_ext | m_pend;
         m_pend = 1'b0;
         m_cap  = 1'b0;
         m_w    = 16'h0000;
         mq.push_back(din);
         if (m_slp) begin
            void'(mq.pop_front());
         end else if (mq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
               m_col = mq[i];
               for (int k = 0; k < 4; k++) m_w[4*k + i] = m_col[k];
            end
            mq.delete();
            m_cap = 1'b1;
            m_dout = m_w;
         end
         m_vld = m_cap;
         m_rise = train & ~m_prev_train;
         m_prev_train = train;
         m_old = m_mode;
         if (m_mode == M_IDLE) begin
            if (train) begin m_mode = M_SEARCH; m_slips = 0; end
         end else if (m_mode == M_LOCKED) begin
            if (m_rise) begin
               m_mode = M_SEARCH; m_slips = 0;
            end else if (m_cap && train && m_w != SYNC) begin
`ifdef HR_4T16_DEMUX_ERRCNT_EN
               if (m_err != 8'hFF) m_err = m_err + 8'h01;
`endif
            end
         end else if (m_mode == M_FAIL) begin
            if (!train) m_mode = M_IDLE;
         end else if (!train) begin
            m_mode = M_IDLE;
         end else if (m_cap) begin
            if (m_mode == M_DISCARD) begin
               m_mode = M_SEARCH;
            end else if (m_w == SYNC) begin
               m_matches = (m_mode == M_SEARCH) ? 1 : m_matches + 1;
               m_mode = (m_matches >= LOCK_CNT) ? M_LOCKED : M_CHECK;
            end else if (m_slips >= MAX_SLIPS) begin
               m_mode = M_FAIL;
            end else begin
               m_pend = 1'b1; m_slips++; m_mode = M_DISCARD;
            end
         end
         if (m_mode == M_SEARCH && m_old != M_SEARCH) m_err = 8'h00;
      end
      m_locked = (m_mode == M_LOCKED);
      m_fail   = (m_mode == M_FAIL);
   end

   always @(negedge clk_hr) begin
      if (m_init) begin
         chk("dout", dout, m_dout);
         chk("dout_vld", 16'(dout_vld), 16'(m_vld));
         chk("locked", 16'(locked), 16'(m_locked));
         chk("align_fail", 16'(align_fail), 16'(m_fail));
         chk("err_cnt", 16'(err_cnt), 16'(m_err));
      end
   end

   task automatic drive(input logic [3:0] d, input logic t, input logic s, input logic r);
      @(negedge clk_hr);
      din = d; train = t; slip_ext = s; rst_n = r;
   endtask

   task automatic send_stream(input logic [15:0] w, input logic t, input int n);
      logic [3:0] d;
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < 4; k++) d[k] = w[4*k + (gpos % 4)];
         drive(d, t, 1'b0, 1'b1);
         gpos++;
      end
   endtask

   task automatic do_reset();
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
      gpos = 0;
   endtask

   initial begin
      int first;
      drive(4'h0, 1'b0, 1'b0, 1'b0);
      drive(4'h0, 1'b0, 1'b0, 1'b0);

      // Reset mid-word, then measure edges to the first word strobe (reset edge counts as 1).
      for (int j = 0; j < 7; j++) drive(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
      do_reset();
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
      chk("rst_dout", dout, 16'h0000);
      chk("rst_vld", 16'(dout_vld), 16'h0000);
      chk("rst_locked", 16'(locked), 16'h0000);
      first = 0;
      for (int e = 2; e <= 8; e++) begin
         drive(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
         if (dout_vld && first == 0) first = e;
      end
      chk("vld_latency", 16'(first), 16'd5);

      // Pass-through with training off.
      do_reset();
      send_stream(16'hBEEF, 1'b0, 20);
      chk("pass_beef", dout, 16'hBEEF);
      chk("pass_unlocked", 16'(locked), 16'h0000);
      send_stream(16'hA5C3, 1'b0, 8);
      chk("pass_a5c3", dout, 16'hA5C3);

      // Aligned training: lock appears right after the fourth matching capture.
      do_reset();
      send_stream(SYNC, 1'b1, 16);
      chk("lock_not_yet", 16'(locked), 16'h0000);
      send_stream(SYNC, 1'b1, 1);
      chk("lock_4th", 16'(locked), 16'h0001);
      chk("lock_model_slips0", 16'(m_slips), 16'h0000);
      send_stream(SYNC, 1'b0, 15);
      drive(4'h0, 1'b0, 1'b1, 1'b1);
      gpos++;
      send_stream(SYNC, 1'b0, 12);
      chk("manual_slip_keeps_lock", 16'(locked), 16'h0001);

      // No valid pattern: constant ones exhaust the slip budget.
      do_reset();
      send_stream(16'hFFFF, 1'b1, 160);
      chk("fail_set", 16'(align_fail), 16'h0001);
      chk("fail_unlocked", 16'(locked), 16'h0000);
      chk("fail_model_slips", 16'(m_slips), 16'd8);
      send_stream(16'hFFFF, 1'b0, 2);
      chk("fail_cleared", 16'(align_fail), 16'h0000);

      // Two-bit misalignment needs exactly two slips.
      do_reset();
      gpos = 2;
      send_stream(SYNC, 1'b1, 50);
      chk("mis2_locked", 16'(locked), 16'h0001);
      chk("mis2_dout", dout, 16'h1E2D);
      chk("mis2_model_slips", 16'(m_slips), 16'd2);

`ifdef HR_4T16_DEMUX_ERRCNT_EN
      send_stream(16'h0000, 1'b1, 12);
      send_stream(SYNC, 1'b1, 8);
      chk("err_three", 16'(err_cnt), 16'd3);
      chk("err_still_locked", 16'(locked), 16'h0001);
      send_stream(16'h0000, 1'b1, 1200);
      send_stream(SYNC, 1'b1, 8);
      chk("err_saturated", 16'(err_cnt), 16'h00FF);
`endif

      send_stream(SYNC, 1'b1, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
